// File: rtl/fanctrl_pkg.sv
// Shared widths, accumulator sizing and FSM state encoding for the PID sequencer.
package fanctrl_pkg;

    localparam int ADC_BW_DEF  = 4;
    localparam int COEF_BW_DEF = 8;
    localparam int FRAC_BW_DEF = 6;

    // Accumulator headroom: product width plus enough bits for five summed terms.
    function automatic int acc_width(input int coef_bw, input int adc_bw);
        return coef_bw + adc_bw + 4;
    endfunction

    localparam int ACC_BW_DEF = acc_width(COEF_BW_DEF, ADC_BW_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        SAT  = 2'd2
    } state_t;

endpackage

// File: rtl/pid_mac.sv
// Combinational signed multiply-add: acc_o = acc_i +/- coef_i * opnd_i.
module pid_mac #(
    parameter int COEF_W = 8,
    parameter int OP_W   = 5,
    parameter int ACC_W  = 16
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [COEF_W-1:0] coef_i,
    input  logic [OP_W-1:0]   opnd_i,
    input  logic              sub_i,
    output logic [ACC_W-1:0]  acc_o
);

    localparam int PW = COEF_W + OP_W;

    logic signed [PW-1:0]    coef_x;
    logic signed [PW-1:0]    opnd_x;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_ext;

    // Sign-extend both factors to the full product width so the multiply is exact.
    assign coef_x   = {{OP_W{coef_i[COEF_W-1]}}, coef_i};
    assign opnd_x   = {{COEF_W{opnd_i[OP_W-1]}}, opnd_i};
    assign prod     = coef_x * opnd_x;
    assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
    assign acc_o    = sub_i ? (acc_i - prod_ext) : (acc_i + prod_ext);

endmodule

// File: rtl/pid_sequencer.sv
// Time-multiplexed 2nd-order controller step: one shared multiplier, five MAC
// cycles, then a scale/clip cycle. Define PID_SAT_EN to clip y to the signed
// ADC_BITWIDTH+1 range (sat_o reports clipping); otherwise y wraps and sat_o is 0.
module pid_sequencer
    import fanctrl_pkg::*;
#(
    parameter int ADC_BITWIDTH  = ADC_BW_DEF,
    parameter int COEF_BITWIDTH = COEF_BW_DEF,
    parameter int FRAC_BITWIDTH = FRAC_BW_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     clear_i,
    input  logic [ADC_BITWIDTH-1:0]  adc_i,
    input  logic [ADC_BITWIDTH-1:0]  set_i,
    input  logic [COEF_BITWIDTH-1:0] b2_i,
    input  logic [COEF_BITWIDTH-1:0] b1_i,
    input  logic [COEF_BITWIDTH-1:0] b0_i,
    input  logic [COEF_BITWIDTH-1:0] a1_i,
    input  logic [COEF_BITWIDTH-1:0] a0_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [ADC_BITWIDTH:0]    y_o,
    output logic                     sat_o
);

    localparam int XW    = ADC_BITWIDTH + 1;
    localparam int CW    = COEF_BITWIDTH;
    localparam int ACC_W = acc_width(COEF_BITWIDTH, ADC_BITWIDTH);

    state_t            state, state_nxt;
    logic [2:0]        step;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [XW-1:0]     x0, x1, x2, y1, y2, x_new;
    logic [CW-1:0]     b2_s, b1_s, b0_s, a1_s, a0_s;
    logic [CW-1:0]     coef_sel;
    logic [XW-1:0]     opnd_sel;
    logic              sub_sel;
    logic [XW-1:0]     y_new;
    logic              sat_new;
    logic              start_go, clr_go;

    // The done cycle is already IDLE but still counts as busy, so gate on it too.
    assign busy_o   = (state != IDLE) | done_o;
    assign start_go = (state == IDLE) & ~done_o & start_i;
    assign clr_go   = (state == IDLE) & ~done_o & clear_i;
    assign x_new    = {1'b0, set_i} - {1'b0, adc_i};

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: IDLE -> MAC on start, five MAC cycles, one SAT cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_go) state_nxt = MAC;
            MAC:     if (step == 3'd4) state_nxt = SAT;
            SAT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pick coefficient/operand pair for the current MAC step.
    always_comb begin
        coef_sel = b2_s;
        opnd_sel = x0;
        sub_sel  = 1'b0;
        case (step)
            3'd1:    begin coef_sel = b1_s; opnd_sel = x1; end
            3'd2:    begin coef_sel = b0_s; opnd_sel = x2; end
            3'd3:    begin coef_sel = a1_s; opnd_sel = y1; sub_sel = 1'b1; end
            3'd4:    begin coef_sel = a0_s; opnd_sel = y2; sub_sel = 1'b1; end
            default: ;
        endcase
    end

    pid_mac #(
        .COEF_W (CW),
        .OP_W   (XW),
        .ACC_W  (ACC_W)
    ) u_mac (
        .acc_i  (acc),
        .coef_i (coef_sel),
        .opnd_i (opnd_sel),
        .sub_i  (sub_sel),
        .acc_o  (acc_nxt)
    );

`ifdef PID_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << ADC_BITWIDTH) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(1 << ADC_BITWIDTH));
    logic signed [ACC_W-1:0] acc_sh;

    // Floor-scale the accumulator and clip into the output range.
    always_comb begin
        acc_sh  = $signed(acc) >>> FRAC_BITWIDTH;
        y_new   = acc_sh[XW-1:0];
        sat_new = 1'b0;
        if (acc_sh > Y_MAX) begin
            y_new   = Y_MAX[XW-1:0];
            sat_new = 1'b1;
        end else if (acc_sh < Y_MIN) begin
            y_new   = Y_MIN[XW-1:0];
            sat_new = 1'b1;
        end
    end
`else
    // Floor-scale the accumulator and keep the low bits (wrap-around).
    always_comb begin
        y_new   = acc[FRAC_BITWIDTH+XW-1:FRAC_BITWIDTH];
        sat_new = 1'b0;
    end
`endif

    // Datapath: shadow capture, accumulation, result/history update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            step   <= '0;
            acc    <= '0;
            x0     <= '0; x1 <= '0; x2 <= '0;
            y1     <= '0; y2 <= '0;
            b2_s   <= '0; b1_s <= '0; b0_s <= '0; a1_s <= '0; a0_s <= '0;
            y_o    <= '0;
            sat_o  <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_go) begin
                        x1 <= '0; x2 <= '0; y1 <= '0; y2 <= '0;
                    end
                    if (start_go) begin
                        x0   <= x_new;
                        b2_s <= b2_i; b1_s <= b1_i; b0_s <= b0_i;
                        a1_s <= a1_i; a0_s <= a0_i;
                        acc  <= '0;
                        step <= '0;
                    end
                end
                MAC: begin
                    acc  <= acc_nxt;
                    step <= step + 3'd1;
                end
                SAT: begin
                    y_o    <= y_new;
                    sat_o  <= sat_new;
                    done_o <= 1'b1;
                    x2     <= x1;
                    x1     <= x0;
                    y2     <= y1;
                    y1     <= y_new;
                end
                default: ;
            endcase
        end
    end

endmodule
